chebyshev_stim_source: RTL and testbench

- Streaming stimulus transmitter that drives the sink side (sink_valid/sink_ready/data) of the Chebyshev approximation datapath.
- Generates a programmable linear sweep of WL-bit input samples: start value, step and beat count.
- Honours valid/ready backpressure and frames the sweep with start/end-of-packet markers.
- Used for on-chip characterisation of the approximation error across the input range, and as the input feeder in system benches.

---
 rtl/chebyshev_pkg.sv | 13 +
 rtl/chebyshev_sweep_counter.sv | 37 +++
 rtl/chebyshev_stim_source.sv | 144 ++++++++++++++
 tb/tb_chebyshev_stim_source.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/chebyshev_pkg.sv
// Shared definitions for the Chebyshev stimulus path: sweep FSM encoding and
// default stream/counter widths so producer and consumer agree by construction.
package chebyshev_pkg;

  localparam int unsigned CHEB_WL    = 16;
  localparam int unsigned CHEB_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/chebyshev_sweep_counter.sv
// Beats-remaining counter for a sweep, with flags for the final beat and the
// one before it (the latter pre-computes eop for the next beat).
module chebyshev_sweep_counter
  import chebyshev_pkg::*;
#(
  parameter int unsigned CNT_W = CHEB_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             dec,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             last,
  output logic             second_last
);

  logic [CNT_W-1:0] r_remaining;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_remaining <= '0;
    end else if (clear) begin
      r_remaining <= '0;
    end else if (load) begin
      r_remaining <= load_val;
    end else if (dec) begin
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  assign last        = (r_remaining == CNT_W'(1));
  assign second_last = (r_remaining == CNT_W'(2));

endmodule

// File: rtl/chebyshev_stim_source.sv
// Streaming linear-sweep stimulus source: emits cfg_count samples starting at
// cfg_start and stepping by cfg_step (mod 2^WL), with valid/ready and sop/eop.
module chebyshev_stim_source
  import chebyshev_pkg::*;
#(
  parameter int unsigned WL    = CHEB_WL,
  parameter int unsigned CNT_W = CHEB_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WL-1:0]    cfg_start,
  input  logic [WL-1:0]    cfg_step,
  input  logic [CNT_W-1:0] cfg_count,
  output logic [WL-1:0]    data_out,
  output logic             source_valid,
  input  logic             source_ready,
  output logic             sop,
  output logic             eop,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  sweep_state_e  r_state;
  sweep_state_e  w_state_nxt;
  logic [WL-1:0] r_data;
  logic [WL-1:0] r_step;
  logic          r_valid;
  logic          r_sop;
  logic          r_eop;
  logic          r_done;
  logic          r_aborted;

  logic w_xfer;
  logic w_launch;
  logic w_empty;
  logic w_advance;
  logic w_finish;
  logic w_abort;
  logic w_last;
  logic w_second_last;

  assign w_xfer = r_valid & source_ready;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_empty     = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_count != '0) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_empty = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Abort outranks completion, even when the final beat moves this cycle.
        if (abort) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_xfer) begin
          if (w_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_data    <= '0;
      r_step    <= '0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= w_finish | w_empty;
      r_aborted <= w_abort;
      if (w_launch) begin
        r_data  <= cfg_start;
        r_step  <= cfg_step;
        r_valid <= 1'b1;
        r_sop   <= 1'b1;
        r_eop   <= (cfg_count == CNT_W'(1));
      end else if (w_advance) begin
        r_data <= r_data + r_step;
        r_sop  <= 1'b0;
        r_eop  <= w_second_last;
      end else if (w_finish || w_abort) begin
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
      end
    end
  end

  chebyshev_sweep_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock       (clock),
    .resetn      (resetn),
    .load        (w_launch),
    .dec         (w_advance),
    .clear       (w_finish | w_abort),
    .load_val    (cfg_count),
    .last        (w_last),
    .second_last (w_second_last)
  );

  assign data_out     = r_data;
  assign source_valid = r_valid;
  assign sop          = r_sop;
  assign eop          = r_eop;
  assign busy         = (r_state == ST_RUN);
  assign done         = r_done;
  assign aborted      = r_aborted;

endmodule

// File: tb/tb_chebyshev_stim_source.sv
// Self-checking bench for chebyshev_stim_source: directed and random sweeps
// compared beat-by-beat against an arithmetic model of the expected sequence.
module tb_chebyshev_stim_source;

  localparam int WL    = 16;
  localparam int CNT_W = 16;

  logic             clock        = 1'b0;
  logic             resetn       = 1'b0;
  logic             start        = 1'b0;
  logic             abort        = 1'b0;
  logic             source_ready = 1'b0;
  logic [WL-1:0]    cfg_start    = '0;
  logic [WL-1:0]    cfg_step     = '0;
  logic [CNT_W-1:0] cfg_count    = '0;
  logic [WL-1:0]    data_out;
  logic             source_valid;
  logic             sop;
  logic             eop;
  logic             busy;
  logic             done;
  logic             aborted;

  int n_tests = 0;
  int n_fail  = 0;
  bit ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clock = ~clock;

  chebyshev_stim_source #(
    .WL    (WL),
    .CNT_W (CNT_W)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .abort        (abort),
    .cfg_start    (cfg_start),
    .cfg_step     (cfg_step),
    .cfg_count    (cfg_count),
    .data_out     (data_out),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .sop          (sop),
    .eop          (eop),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Launch one sweep and follow it to its done/aborted pulse.
  // mode: 0 ready always high, 1 random ready, 2 fixed ready pattern.
  // abort_at >= 0 raises abort while that many beats have been accepted;
  // abort_at == -2 holds abort high together with start in IDLE.
  task automatic run_sweep(input logic [WL-1:0] s, input logic [WL-1:0] st, input int cnt,
                           input int mode, input int abort_at, input bit poke_start);
    int          k          = 0;
    int          cyc        = 0;
    bit          abort_seen = 1'b0;
    logic [31:0] exp_d;
    cfg_start = s;
    cfg_step  = st;
    cfg_count = CNT_W'(cnt);
    start     = 1'b1;
    abort     = (abort_at == -2);
    @(posedge clock); #1;
    start = 1'b0;
    forever begin
      cfg_start = WL'($urandom);
      cfg_step  = WL'($urandom);
      cfg_count = CNT_W'($urandom);
      case (mode)
        0:       source_ready = 1'b1;
        1:       source_ready = 1'($urandom_range(0, 1));
        default: source_ready = ready_pat[cyc % 6];
      endcase
      abort = (abort_at >= 0) && (k == abort_at) && (k < cnt) && !abort_seen;
      start = poke_start && (k < cnt) && !abort_seen && ($urandom_range(0, 2) == 0);
      @(negedge clock);
      if (abort_seen) begin
        check("aborted_pulse", 32'(aborted), 32'd1);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_valid", 32'(source_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sop_eop", 32'({sop, eop}), 32'd0);
        break;
      end
      if (k == cnt) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_no_abort", 32'(aborted), 32'd0);
        check("end_valid", 32'(source_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_eop", 32'(eop), 32'd0);
        break;
      end
      exp_d = (32'(s) + 32'(k) * 32'(st)) & 32'h0000_FFFF;
      check("beat_valid", 32'(source_valid), 32'd1);
      check("beat_busy", 32'(busy), 32'd1);
      check("beat_data", 32'(data_out), exp_d);
      check("beat_sop", 32'(sop), 32'(k == 0));
      check("beat_eop", 32'(eop), 32'(k == cnt - 1));
      check("beat_no_pulse", 32'({done, aborted}), 32'd0);
      if (source_ready) k++;
      abort_seen = abort;
      cyc++;
      if (cyc > 8 * cnt + 16) begin
        check("sweep_timeout", 32'(k), 32'(cnt));
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("pulse_width", 32'({done, aborted}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    check("reset_outputs", 32'({data_out, source_valid, sop, eop, busy, done, aborted}), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    run_sweep(16'h0000, 16'h0100, 4, 0, -1, 1'b0);   // basic sweep
    run_sweep(16'h0000, 16'h0001, 3, 2, -1, 1'b0);   // backpressure pattern
    run_sweep(16'hFFFE, 16'h0001, 4, 0, -1, 1'b0);   // wrap-around
    run_sweep(16'h0001, 16'hFFFF, 3, 0, -1, 1'b0);   // negative step
    run_sweep(16'h1234, 16'h0001, 0, 0, -1, 1'b0);   // empty sweep
    run_sweep(16'hABCD, 16'h0001, 1, 0, -1, 1'b0);   // single beat
    run_sweep(16'h0010, 16'h0003, 10, 0, 3, 1'b0);   // abort mid-sweep
    run_sweep(16'h0020, 16'h0005, 6, 0, -1, 1'b0);   // full sweep after abort
    run_sweep(16'h0100, 16'h0011, 5, 0, 4, 1'b0);    // abort on final beat
    run_sweep(16'h0200, 16'h0002, 3, 0, -2, 1'b0);   // start and abort together
    run_sweep(16'h4000, 16'h0101, 8, 1, -1, 1'b1);   // start poked during RUN

    for (int n = 0; n < 25; n++) begin
      run_sweep(WL'($urandom), WL'($urandom), $urandom_range(0, 12), 1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1, 1'b1);
    end

    // Reset in the middle of a sweep.
    cfg_start    = 16'h1000;
    cfg_step     = 16'h0010;
    cfg_count    = 16'd10;
    source_ready = 1'b1;
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("rst_pre_beat", 32'(data_out), 32'h1000 + 32'(16 * i));
    end
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_outputs", 32'({data_out, source_valid, sop, eop, busy, done, aborted}), 32'd0);
    @(posedge clock); #1;
    check("rst_no_pulse", 32'({source_valid, busy, done, aborted}), 32'd0);
    @(negedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    run_sweep(16'h7FFF, 16'h0001, 3, 1, -1, 1'b0);   // recovery after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
